// File: rtl/shifter_sequencer_pkg.sv
// Shared types and constants for the shifter sequencer: shift kinds, FSM states, word width.
package shifter_sequencer_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ShLsl = 2'b00,
    ShLsr = 2'b01,
    ShAsr = 2'b10,
    ShRor = 2'b11
  } shift_kind_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/shifter_sequencer_if.sv
// Request/response bundle between the EXE stage (master) and the shifter sequencer (slave).
interface shifter_sequencer_if;

  logic                                    valid;
  logic [shifter_sequencer_pkg::WORD_W-1:0] Rm;
  logic [7:0]                              Rs_low;
  logic [11:0]                             shift_operand;
  logic                                    immediate;
  logic                                    is_mem_instruction;
  logic                                    reg_shift;
  logic                                    carry_in;
  logic                                    flush;
  logic                                    ready;
  logic                                    stall;
  logic                                    result_valid;
  logic [shifter_sequencer_pkg::WORD_W-1:0] result;
  logic                                    carry_out;

  modport master (
    output valid, Rm, Rs_low, shift_operand, immediate, is_mem_instruction, reg_shift,
    output carry_in, flush,
    input  ready, stall, result_valid, result, carry_out
  );

  modport slave (
    input  valid, Rm, Rs_low, shift_operand, immediate, is_mem_instruction, reg_shift,
    input  carry_in, flush,
    output ready, stall, result_valid, result, carry_out
  );

endinterface

// File: rtl/shifter_sequencer_shift_step.sv
// shift_step: combinational 0..STEP-bit LSL/LSR/ASR/ROR stage returning the last bit shifted out.
module shift_step
  import shifter_sequencer_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic [WORD_W-1:0]          acc_i,
  input  shift_kind_e                kind_i,
  input  logic [$clog2(STEP+1)-1:0]  amt_i,
  input  logic                       carry_i,
  output logic [WORD_W-1:0]          acc_o,
  output logic                       carry_o
);

  // One guard bit beside the word catches the last bit shifted out.
  logic [WORD_W:0] ext;

  always_comb begin
    ext     = '0;
    acc_o   = acc_i;
    carry_o = carry_i;
    unique case (kind_i)
      ShLsl: begin
        ext     = {1'b0, acc_i} << amt_i;
        acc_o   = ext[WORD_W-1:0];
        carry_o = ext[WORD_W];
      end
      ShLsr: begin
        ext     = {acc_i, 1'b0} >> amt_i;
        acc_o   = ext[WORD_W:1];
        carry_o = ext[0];
      end
      ShAsr: begin
        ext     = $signed({acc_i, 1'b0}) >>> amt_i;
        acc_o   = ext[WORD_W:1];
        carry_o = ext[0];
      end
      ShRor: begin
        acc_o   = (acc_i >> amt_i) | (acc_i << (WORD_W - amt_i));
        carry_o = acc_o[WORD_W-1];
      end
      default: ;
    endcase
    if (amt_i == '0) begin
      carry_o = carry_i;
    end
  end

endmodule

// File: rtl/shifter_sequencer.sv
// Multi-cycle second-operand shifter: decodes at accept, then shifts STEP bits per cycle.
// Optional ARM shifter carry output is built only when SHIFTER_CARRY_OUT_EN is defined.
module shifter_sequencer
  import shifter_sequencer_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input logic               clk,
  input logic               rst,
  shifter_sequencer_if.slave bus
);

  localparam int unsigned AmtW    = $clog2(STEP + 1);
  localparam logic [5:0]  StepAmt = 6'(STEP);

  state_e              state_q, state_d;
  shift_kind_e         kind_q, kind_d, dec_kind;
  logic [WORD_W-1:0]   acc_q, acc_d, dec_acc, step_acc, result_q, result_d;
  logic [5:0]          rem_q, rem_d, dec_amt;
  logic [AmtW-1:0]     step_amt;
  logic [4:0]          imm_amt;
  logic                ready_q, ready_d, stall_q, stall_d, rv_q, rv_d;
  logic                accept;

  assign imm_amt = bus.shift_operand[11:7];
  assign accept  = (state_q == StIdle) && bus.valid && !bus.flush;

  // Remaining amount is counted in bits; the last iteration takes whatever is left.
  assign step_amt = (rem_q > StepAmt) ? AmtW'(STEP) : AmtW'(rem_q);

  always_comb begin
    dec_kind = shift_kind_e'(bus.shift_operand[6:5]);
    dec_acc  = bus.Rm;
    dec_amt  = '0;
    if (bus.is_mem_instruction) begin
      dec_acc  = {{20{bus.shift_operand[11]}}, bus.shift_operand};
      dec_kind = ShLsl;
    end else if (bus.immediate) begin
      dec_acc  = {24'b0, bus.shift_operand[7:0]};
      dec_kind = ShRor;
      dec_amt  = {1'b0, bus.shift_operand[11:8], 1'b0};
    end else if (bus.reg_shift) begin
      if (bus.Rs_low == 8'd0) begin
        dec_amt = '0;
      end else if (dec_kind == ShRor) begin
        dec_amt = {1'b0, bus.Rs_low[4:0]};
      end else if (bus.Rs_low > 8'd32) begin
        dec_amt = 6'd32;
      end else begin
        dec_amt = bus.Rs_low[5:0];
      end
    end else begin
      unique case (dec_kind)
        ShLsl:        dec_amt = {1'b0, imm_amt};
        ShLsr, ShAsr: dec_amt = (imm_amt == 5'd0) ? 6'd32 : {1'b0, imm_amt};
        ShRor: begin
          if (imm_amt == 5'd0) begin
            dec_acc = {bus.carry_in, bus.Rm[WORD_W-1:1]};
          end else begin
            dec_amt = {1'b0, imm_amt};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFTER_CARRY_OUT_EN
  logic carry_q, carry_d, over_q, over_d, cout_q, cout_d, step_carry;
  logic dec_carry, dec_over;

  // RRX seeds the carry with Rm[0]; LSL/LSR beyond 32 force a zero carry at the end.
  always_comb begin
    dec_carry = bus.carry_in;
    dec_over  = 1'b0;
    if (!bus.is_mem_instruction && !bus.immediate) begin
      if (!bus.reg_shift && dec_kind == ShRor && imm_amt == 5'd0) begin
        dec_carry = bus.Rm[0];
      end
      if (bus.reg_shift && bus.Rs_low > 8'd32 && (dec_kind == ShLsl || dec_kind == ShLsr)) begin
        dec_over = 1'b1;
      end
    end
  end

  always_comb begin
    carry_d = carry_q;
    over_d  = over_q;
    cout_d  = cout_q;
    if (accept) begin
      carry_d = dec_carry;
      over_d  = dec_over;
    end else if (state_q == StShift && !bus.flush) begin
      carry_d = step_carry;
    end
    if (state_d == StDone) begin
      cout_d = over_d ? 1'b0 : carry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      over_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      over_q  <= over_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.carry_out = cout_q;
`else
  assign bus.carry_out = 1'b0;
`endif

  shift_step #(
    .STEP(STEP)
  ) u_shift_step (
    .acc_i   (acc_q),
    .kind_i  (kind_q),
    .amt_i   (step_amt),
`ifdef SHIFTER_CARRY_OUT_EN
    .carry_i (carry_q),
    .carry_o (step_carry),
`else
    .carry_i (1'b0),
    .carry_o (),
`endif
    .acc_o   (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    kind_d   = kind_q;
    rem_d    = rem_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = dec_acc;
          kind_d  = dec_kind;
          rem_d   = dec_amt;
          state_d = (dec_amt == 6'd0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step_acc;
          rem_d = rem_q - 6'(step_amt);
          if (rem_d == 6'd0) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Result only moves on a completed operation, so a flush leaves the old value visible.
    if (state_d == StDone) begin
      result_d = acc_d;
    end
    ready_d = (state_d == StIdle);
    stall_d = (state_d != StIdle);
    rv_d    = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      kind_q   <= ShLsl;
      rem_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      stall_q  <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      kind_q   <= kind_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      stall_q  <= stall_d;
      rv_q     <= rv_d;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.stall        = stall_q;
  assign bus.result_valid = rv_q;
  assign bus.result       = result_q;

endmodule

// File: tb/tb_shifter_sequencer.sv
// Randomised bench for shifter_sequencer at STEP=1/4/8 against an arithmetic reference model.
module tb_shifter_sequencer;

  localparam int NDut = 3;
  localparam int unsigned Steps [NDut] = '{1, 4, 8};

  logic clk, rst;
  logic t_valid, t_imm, t_mem, t_reg, t_cin, t_flush;
  logic [31:0] t_rm;
  logic [7:0]  t_rs;
  logic [11:0] t_so;

  shifter_sequencer_if if_s1 ();
  shifter_sequencer_if if_s4 ();
  shifter_sequencer_if if_s8 ();

  assign if_s1.valid = t_valid;  assign if_s4.valid = t_valid;  assign if_s8.valid = t_valid;
  assign if_s1.Rm = t_rm;        assign if_s4.Rm = t_rm;        assign if_s8.Rm = t_rm;
  assign if_s1.Rs_low = t_rs;    assign if_s4.Rs_low = t_rs;    assign if_s8.Rs_low = t_rs;
  assign if_s1.shift_operand = t_so;
  assign if_s4.shift_operand = t_so;
  assign if_s8.shift_operand = t_so;
  assign if_s1.immediate = t_imm; assign if_s4.immediate = t_imm; assign if_s8.immediate = t_imm;
  assign if_s1.is_mem_instruction = t_mem;
  assign if_s4.is_mem_instruction = t_mem;
  assign if_s8.is_mem_instruction = t_mem;
  assign if_s1.reg_shift = t_reg; assign if_s4.reg_shift = t_reg; assign if_s8.reg_shift = t_reg;
  assign if_s1.carry_in = t_cin;  assign if_s4.carry_in = t_cin;  assign if_s8.carry_in = t_cin;
  assign if_s1.flush = t_flush;   assign if_s4.flush = t_flush;   assign if_s8.flush = t_flush;

  logic        rv [NDut], rdy [NDut], stl [NDut], co [NDut];
  logic [31:0] res [NDut];
  assign rv[0] = if_s1.result_valid; assign rv[1] = if_s4.result_valid;
  assign rv[2] = if_s8.result_valid;
  assign rdy[0] = if_s1.ready; assign rdy[1] = if_s4.ready; assign rdy[2] = if_s8.ready;
  assign stl[0] = if_s1.stall; assign stl[1] = if_s4.stall; assign stl[2] = if_s8.stall;
  assign co[0] = if_s1.carry_out; assign co[1] = if_s4.carry_out; assign co[2] = if_s8.carry_out;
  assign res[0] = if_s1.result; assign res[1] = if_s4.result; assign res[2] = if_s8.result;

  shifter_sequencer #(.STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if_s1));
  shifter_sequencer #(.STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if_s4));
  shifter_sequencer #(.STEP(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if_s8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total, bad;
  logic [31:0] prev_res [NDut];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int a);
    logic [63:0] d;
    d = {x, x} >> (a % 32);
    return d[31:0];
  endfunction

  // Reference: final operand, ARM shifter carry and effective amount from the decode rules.
  task automatic ref_model(input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] so,
                           input logic imm, input logic mem, input logic regs, input logic cin,
                           output logic [31:0] r, output logic c, output int a);
    int kind, raw;
    kind = int'(so[6:5]);
    if (mem) begin
      r = {{20{so[11]}}, so}; c = cin; a = 0;
    end else if (imm) begin
      a = 2 * int'(so[11:8]);
      r = rotr({24'b0, so[7:0]}, a);
      c = (a == 0) ? cin : r[31];
    end else if (!regs && kind == 3 && so[11:7] == 5'd0) begin
      a = 0; r = {cin, rm[31:1]}; c = rm[0];
    end else begin
      if (regs) raw = int'(rs);
      else if (so[11:7] == 5'd0 && (kind == 1 || kind == 2)) raw = 32;
      else raw = int'(so[11:7]);
      if (regs && kind == 3) a = raw % 32;
      else a = (raw > 32) ? 32 : raw;
      if (a == 0) begin
        r = rm; c = cin;
      end else begin
        case (kind)
          0: begin r = (a == 32) ? 32'd0 : rm << a;  c = (raw > 32) ? 1'b0 : rm[32 - a]; end
          1: begin r = (a == 32) ? 32'd0 : rm >> a;  c = (raw > 32) ? 1'b0 : rm[a - 1]; end
          2: begin
            r = (a == 32) ? {32{rm[31]}} : 32'($signed(rm) >>> a);
            c = rm[a - 1];
          end
          default: begin r = rotr(rm, a); c = rm[a - 1]; end
        endcase
      end
    end
  endtask

  // flush_at: sample cycle after accept in which flush (or rst when use_rst) is raised; 0 = none.
  task automatic run_op(input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] so,
                        input logic imm, input logic mem, input logic regs, input logic cin,
                        input int flush_at, input bit use_rst);
    logic [31:0] er, got_r [NDut];
    logic        ec, exp_c, got_c [NDut];
    int a, n, k [NDut], lat [NDut], scnt [NDut];
    ref_model(rm, rs, so, imm, mem, regs, cin, er, ec, a);
`ifdef SHIFTER_CARRY_OUT_EN
    exp_c = ec;
`else
    exp_c = 1'b0;
`endif
    @(negedge clk);
    t_rm = rm; t_rs = rs; t_so = so; t_imm = imm; t_mem = mem; t_reg = regs; t_cin = cin;
    t_valid = 1'b1; t_flush = 1'b0;
    for (int d = 0; d < NDut; d++) begin
      check("ready_before_accept", 32'(rdy[d]), 32'd1);
      k[d] = (a + int'(Steps[d]) - 1) / int'(Steps[d]);
      lat[d] = 0; scnt[d] = 0; got_r[d] = '0; got_c[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    t_rm = $urandom; t_rs = 8'($urandom); t_so = 12'($urandom); t_cin = 1'($urandom);
    t_imm = 1'($urandom); t_mem = 1'($urandom); t_reg = 1'($urandom);
    n = a + 2;
    for (int cyc = 1; cyc <= n; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < NDut; d++) begin
        if (rv[d] && lat[d] == 0) begin
          lat[d] = cyc; got_r[d] = res[d]; got_c[d] = co[d];
        end
        if (stl[d]) scnt[d]++;
        if (cyc == 1) check("ready_drop", 32'(rdy[d]), 32'd0);
      end
      if (flush_at != 0 && cyc == flush_at) begin
        if (use_rst) rst = 1'b1;
        else t_flush = 1'b1;
      end
      if (flush_at != 0 && cyc == flush_at + 1) begin
        rst = 1'b0; t_flush = 1'b0;
      end
    end
    for (int d = 0; d < NDut; d++) begin
      if (flush_at == 0 || k[d] + 1 < flush_at) begin
        check("latency", 32'(lat[d]), 32'(k[d] + 1));
        check("result", got_r[d], er);
        check("carry_out", 32'(got_c[d]), 32'(exp_c));
        check("stall_cycles", 32'(scnt[d]), 32'(k[d] + 1));
        prev_res[d] = er;
      end else begin
        check("no_result_valid", 32'(lat[d]), 32'd0);
      end
      if (flush_at != 0 && use_rst) begin
        prev_res[d] = '0;
        check("carry_after_rst", 32'(co[d]), 32'd0);
      end
      check("result_held", res[d], prev_res[d]);
      check("ready_after", 32'(rdy[d]), 32'd1);
    end
  endtask

  task automatic flush_idle();
    @(negedge clk);
    t_valid = 1'b1; t_flush = 1'b1; t_so = 12'($urandom); t_mem = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDut; d++) begin
      check("flush_idle_ready", 32'(rdy[d]), 32'd1);
      check("flush_idle_rv", 32'(rv[d]), 32'd0);
    end
    t_valid = 1'b0; t_flush = 1'b0;
  endtask

  initial begin
    logic [7:0]  rs;
    logic [11:0] so;
    total = 0; bad = 0;
    rst = 1'b1; t_valid = 1'b0; t_flush = 1'b0; t_rm = '0; t_rs = '0; t_so = '0;
    t_imm = 1'b0; t_mem = 1'b0; t_reg = 1'b0; t_cin = 1'b0;
    for (int d = 0; d < NDut; d++) prev_res[d] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < NDut; d++) begin
      check("rst_ready", 32'(rdy[d]), 32'd1);
      check("rst_stall", 32'(stl[d]), 32'd0);
      check("rst_rv", 32'(rv[d]), 32'd0);
      check("rst_result", res[d], 32'd0);
      check("rst_carry", 32'(co[d]), 32'd0);
    end

    run_op(32'h1234_5678, 8'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h8000_0000, 8'd40, 12'h020, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    run_op(32'h8000_0001, 8'd0, 12'h040, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h0000_0003, 8'd0, 12'h060, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_op(32'hDEAD_BEEF, 8'd0, 12'h800, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h0000_0F0F, 8'd0, 12'hA00, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    run_op(32'hF000_000F, 8'd32, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    run_op(32'h0000_0F0F, 8'd0, 12'hA00, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    run_op(32'h8765_4321, 8'd33, 12'h060, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    flush_idle();

    for (int i = 0; i < 80; i++) begin
      so = 12'($urandom);
      if ($urandom_range(0, 3) == 0) so[11:7] = 5'd0;
      case ($urandom_range(0, 5))
        0: rs = 8'd0;
        1: rs = 8'd32;
        2: rs = 8'($urandom_range(33, 255));
        3: rs = 8'($urandom_range(1, 31));
        default: rs = 8'($urandom);
      endcase
      run_op($urandom, rs, so, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
             1'($urandom), 1'($urandom), 0, 1'b0);
      if (i % 20 == 7) flush_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shifter_sequencer.md
# shifter_sequencer

Multi-cycle controller for the second-operand path of the EXE stage. It accepts a decoded shifter operand and returns the final operand after N cycles. Immediate, memory-offset and register-specified shifts all go through it. It moves an accumulator through a STEP-bit shift/rotate stage once per cycle, so the EXE stage avoids a full 32-bit barrel shifter. While an operation is in flight it holds `stall` high toward the hazard unit.

## Interface
- STEP, 1: bits shifted per iteration; legal values 1, 2, 4, 8
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  request present; accepted only when `ready`=1
- Rm  in  32  value to shift
- Rs_low  in  8  low byte of Rs (register-specified shift amount)
- shift_operand  in  12  instruction bits [11:0]
- immediate  in  1  I bit: rotated 8-bit immediate
- is_mem_instruction  in  1  LDR/STR offset form
- reg_shift  in  1  shift amount is taken from Rs_low, not from shift_operand[11:7]
- carry_in  in  1  C flag, used for RRX and zero-amount carry
- flush  in  1  abandon the current operation
- ready  out  1  IDLE, can accept
- stall  out  1  operation in flight (state SHIFT or DONE)
- result_valid  out  1  one-cycle pulse, `result` is valid
- result  out  32  final operand, held until the next accept
- carry_out  out  1  shifter carry (see Configuration)

## Operation
- Accept happens when `valid`&&`ready`&&!`flush`. Inputs are sampled only at accept.
- Decode at accept gives the starting accumulator, operation and effective amount A:
  - mem: acc={{20{so[11]}},so}, A=0
  - immediate: acc={24'b0,so[7:0]}, op=ROR, A=2*so[11:8]
  - shift kind = so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR
  - imm shift, amount=so[11:7]:
    - LSL: A=amount
    - LSR/ASR: amount 0 means A=32
    - ROR: amount 0 means RRX, acc={carry_in,Rm[31:1]}, A=0
  - reg shift, amount=Rs_low:
    - 0: A=0
    - LSL/LSR/ASR: A=min(Rs_low,32)
    - ROR: A=Rs_low mod 32
- Iteration count is K=ceil(A/STEP). The final iteration shifts by A−(K−1)·STEP.
- FSM states:
  - IDLE: `ready`=1. On accept, go to DONE if K=0, else go to SHIFT.
  - SHIFT: apply one iteration per cycle (LSL zero-fill, LSR zero-fill, ASR sign-fill, ROR wrap) and decrement the remaining count. Go to DONE when the count reaches 0.
  - DONE: `result_valid`=1, `result`=acc, go to IDLE.
- LSL/LSR by 32 give 0. ASR by 32 gives 32 copies of Rm[31].
- `flush` in SHIFT or DONE returns the FSM to IDLE on the next cycle with no `result_valid`. `result` keeps its old value.
- `flush` in IDLE with `valid` high: flush wins and nothing is accepted.

## Timing
- Reset values: state IDLE, `ready`=1, `stall`=0, `result_valid`=0, `result`=0, `carry_out`=0.
- Latency is K+1 cycles from the accept edge to the `result_valid` cycle. With STEP=1 the worst case is 33.
- The earliest next accept is the cycle after DONE. `ready` drops in the cycle after accept.
- `stall` is registered. It is high from the cycle after accept through the DONE cycle.
- Reset mid-operation is treated like `flush` and also clears `result`.

## Configuration
- SHIFTER_CARRY_OUT_EN defined: `carry_out` is computed as ARM shifter carry.
  - Normally it is the last bit shifted out, tracked per iteration.
  - A=0 (no shift, reg amount 0) gives `carry_in`.
  - RRX gives Rm[0].
  - Immediate with so[11:8]=0 gives `carry_in`. Any other immediate gives result[31].
  - LSL/LSR by exactly 32 give Rm[0] and Rm[31] respectively. Amounts over 32 give 0.
  - The value is valid with `result_valid` and held afterwards.
- SHIFTER_CARRY_OUT_EN undefined: `carry_out` is tied to 0 and the carry tracking registers are not built.

## Structure
- Shared package holds:
  - shift kind encodings LSL/LSR/ASR/ROR (2'b00..2'b11)
  - FSM state enum IDLE/SHIFT/DONE
  - constant WORD_W=32
- One sub-module, `shift_step`: combinational, shifts the accumulator by 0..STEP bits for a given kind and returns the bits shifted out.
- Controller, decode and counter stay in the top module.

## Test plan
- Immediate so=12'h4FF, STEP=1: A=8, `result_valid` 9 cycles after accept, `result`=32'hFF000000.
- Reg LSR, Rm=32'h80000000, Rs_low=40, STEP=4: A=32, K=8, `result`=0; with the macro, `carry_out`=0.
- Imm ASR amount 0, Rm=32'h80000001, STEP=8: K=4, `result`=32'hFFFFFFFF; with the macro, `carry_out`=1.
- RRX, Rm=32'h00000003, carry_in=1: K=0, `result_valid` on the cycle after accept, `result`=32'h80000001; with the macro, `carry_out`=1.
- Mem so=12'h800: `result`=32'hFFFFF800, latency 1 cycle, `stall` high for exactly 1 cycle.
- LSL by 20, STEP=1, `flush` on the 5th SHIFT cycle: no `result_valid`, `ready`=1 on the next cycle, a new request is then accepted normally. Repeat with `rst` in place of `flush`: `result`=0.
